// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
//
// Four-requester round-robin arbiter that shares one downstream resource.
// A rotated priority encoder picks the winner. The scan starts one position
// after the last winner, so no requester can starve. Grants are registered.
// A grant is held until the owner raises done or drops its request. At least
// one IDLE cycle always separates two consecutive grants.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a hold counter forces a release after MAX_HOLD cycles in
//   BUSY and pulses the timeout output for one cycle. When undefined, there
//   is no counter and no timeout port.
//
// Parameters:
//   MAX_HOLD  maximum grant length in cycles (2..255); used only when
//             ARB_TIMEOUT_EN is defined
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   req      in   4  level-sensitive request vector, bit i = requester i
//   done     in   1  owner releases the resource (sampled only in BUSY)
//   gnt      out  4  one-hot grant, zero when there is no owner
//   gnt_id   out  2  binary index of the owner, 2'b00 when idle
//   busy     out  1  high while a grant is held
//   timeout  out  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic [1:0] last_id_q, last_id_d;

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] scan_idx;
  logic       release_now;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotated priority encoder: scan upward from last_id+1, wrapping 3->0.
  // The 2-bit sum wraps by itself, so offset 4 lands back on last_id. That
  // makes the last winner the lowest-priority candidate, which is what lets
  // a lone requester be granted again.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'b00;
    scan_idx  = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_id_q + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Next-state logic for the IDLE/BUSY controller. IDLE launches a grant
  // toward the encoder's winner. BUSY holds the grant until done, until the
  // owner drops its request or, if enabled, until the hold limit is reached.
  // A release always returns to IDLE, which enforces the one-cycle gap
  // between grants.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    busy_d      = busy_q;
    last_id_d   = last_id_q;
    release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = BUSY;
          gnt_d     = 4'b0001 << win_id;
          gnt_id_d  = win_id;
          busy_d    = 1'b1;
          last_id_d = win_id;
`ifdef ARB_TIMEOUT_EN
          hold_d    = 8'd0;
`endif
        end
      end

      BUSY: begin
        // done and an owner drop in the same cycle are one release.
        release_now = done | ~req[gnt_id_q];
`ifdef ARB_TIMEOUT_EN
        // The count is 0 on the first BUSY cycle, so reaching MAX_HOLD-1
        // means the grant has been visible for MAX_HOLD cycles.
        if (!release_now) begin
          if (hold_q == HOLD_LAST) begin
            release_now = 1'b1;
            timeout_d   = 1'b1;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
`endif
        if (release_now) begin
          state_d  = IDLE;
          gnt_d    = 4'b0000;
          gnt_id_d = 2'b00;
          busy_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset puts the pointer at 3, so requester 0 is scanned
  // first after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'b00;
      busy_q    <= 1'b0;
      last_id_q <= 2'b11;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      last_id_q <= last_id_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4
//
// Self-checking bench for rr_arbiter4. Each scenario task drives a small
// table of (rst_n, req, done) steps on the falling edge. For each step it
// pushes the expected {gnt, gnt_id, busy} onto a scoreboard queue. One
// rising edge later, on the next falling edge, it pops that entry and
// compares it with the outputs. Expected values come from the arbitration
// rules, written as table constants or as a short formula for the rotation.
// With ARB_TIMEOUT_EN defined, a forced-release scenario also runs.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  exp_t exp_q[$];
  int   tests_run = 0;
  int   failures  = 0;

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required end before time 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and stop on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for one edge so that the pointer returns to 3.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Reset values hold while rst_n is low, even with all requests and done
  // active. IDLE stays quiet once reset is released with no requests.
  task automatic test_reset();
    logic       r_v [3];
    logic [3:0] q_v [3];
    logic       d_v [3];
    exp_t       e_v [3];
    exp_t       e;
    r_v = '{1'b0, 1'b0, 1'b1};
    q_v = '{4'b1111, 4'b1111, 4'b0000};
    d_v = '{1'b1, 1'b1, 1'b0};
    e_v = '{'{4'b0000, 2'd0, 1'b0}, '{4'b0000, 2'd0, 1'b0}, '{4'b0000, 2'd0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      rst_n = r_v[i]; req = q_v[i]; done = d_v[i];
      exp_q.push_back(e_v[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, gnt_id, busy} !== e) begin
        failures++;
        $display("[TB] FAIL reset step %0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                 i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
      end
    end
  endtask

  // A single requester is granted, released by done, and granted again
  // after the IDLE gap. done seen in IDLE does nothing.
  task automatic test_single();
    logic [3:0] q_v [5];
    logic       d_v [5];
    exp_t       e_v [5];
    exp_t       e;
    do_reset();
    q_v = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    d_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    e_v = '{'{4'b0001, 2'd0, 1'b1}, '{4'b0000, 2'd0, 1'b0}, '{4'b0001, 2'd0, 1'b1},
            '{4'b0000, 2'd0, 1'b0}, '{4'b0000, 2'd0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      req = q_v[i]; done = d_v[i];
      exp_q.push_back(e_v[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, gnt_id, busy} !== e) begin
        failures++;
        $display("[TB] FAIL single step %0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                 i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
      end
    end
    req = 4'b0000; done = 1'b0;
  endtask

  // All four requesters stay high and done is pulsed on every BUSY cycle.
  // Grants must rotate 0,1,2,3,0 with an idle cycle between each.
  task automatic test_round_robin();
    exp_t e;
    exp_t want;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      done = i[0];
      if (i[0]) want = '{4'b0000, 2'd0, 1'b0};
      else      want = '{4'b0001 << ((i / 2) % 4), 2'((i / 2) % 4), 1'b1};
      exp_q.push_back(want);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, gnt_id, busy} !== e) begin
        failures++;
        $display("[TB] FAIL round_robin step %0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                 i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
      end
    end
    req = 4'b0000; done = 1'b0;
    tick();
  endtask

  // After requester 2 wins, with req=0101 the scan wraps from 3 to 0 and
  // requester 0 wins.
  task automatic test_wrap();
    logic [3:0] q_v [4];
    logic       d_v [4];
    exp_t       e_v [4];
    exp_t       e;
    do_reset();
    q_v = '{4'b0100, 4'b0101, 4'b0101, 4'b0000};
    d_v = '{1'b0, 1'b1, 1'b0, 1'b0};
    e_v = '{'{4'b0100, 2'd2, 1'b1}, '{4'b0000, 2'd0, 1'b0}, '{4'b0001, 2'd0, 1'b1},
            '{4'b0000, 2'd0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      req = q_v[i]; done = d_v[i];
      exp_q.push_back(e_v[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, gnt_id, busy} !== e) begin
        failures++;
        $display("[TB] FAIL wrap step %0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                 i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
      end
    end
    done = 1'b0;
  endtask

  // Owner 1 drops its request without done. The next grant goes to 3, and
  // other request bits are ignored while 3 owns the resource.
  task automatic test_owner_drop();
    logic [3:0] q_v [5];
    logic       d_v [5];
    exp_t       e_v [5];
    exp_t       e;
    do_reset();
    q_v = '{4'b0010, 4'b1000, 4'b1000, 4'b1111, 4'b0000};
    d_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    e_v = '{'{4'b0010, 2'd1, 1'b1}, '{4'b0000, 2'd0, 1'b0}, '{4'b1000, 2'd3, 1'b1},
            '{4'b1000, 2'd3, 1'b1}, '{4'b0000, 2'd0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      req = q_v[i]; done = d_v[i];
      exp_q.push_back(e_v[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, gnt_id, busy} !== e) begin
        failures++;
        $display("[TB] FAIL owner_drop step %0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                 i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
      end
    end
  endtask

  // Reset during a grant to 2 clears the outputs and the pointer, so the
  // next contended grant goes to requester 0.
  task automatic test_mid_reset();
    logic       r_v [4];
    logic [3:0] q_v [4];
    exp_t       e_v [4];
    exp_t       e;
    do_reset();
    r_v = '{1'b1, 1'b0, 1'b1, 1'b1};
    q_v = '{4'b0100, 4'b0100, 4'b1111, 4'b0000};
    e_v = '{'{4'b0100, 2'd2, 1'b1}, '{4'b0000, 2'd0, 1'b0}, '{4'b0001, 2'd0, 1'b1},
            '{4'b0000, 2'd0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      rst_n = r_v[i]; req = q_v[i]; done = 1'b0;
      exp_q.push_back(e_v[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, gnt_id, busy} !== e) begin
        failures++;
        $display("[TB] FAIL mid_reset step %0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                 i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
      end
    end
    rst_n = 1'b1;
  endtask

`ifdef ARB_TIMEOUT_EN
  // With MAX_HOLD=4 and no done, the grant lasts exactly four cycles. The
  // forced release pulses timeout once, and the held request is then
  // granted again after the idle gap.
  task automatic test_timeout();
    logic [3:0] q_v [7];
    exp_t       e_v [7];
    logic       t_v [7];
    exp_t       e;
    do_reset();
    q_v = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    e_v = '{'{4'b0010, 2'd1, 1'b1}, '{4'b0010, 2'd1, 1'b1}, '{4'b0010, 2'd1, 1'b1},
            '{4'b0010, 2'd1, 1'b1}, '{4'b0000, 2'd0, 1'b0}, '{4'b0010, 2'd1, 1'b1},
            '{4'b0000, 2'd0, 1'b0}};
    t_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      req = q_v[i]; done = 1'b0;
      exp_q.push_back(e_v[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({gnt, gnt_id, busy} !== e) begin
        failures++;
        $display("[TB] FAIL timeout_grant step %0d: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                 i, gnt, gnt_id, busy, e.gnt, e.id, e.busy);
      end
      tests_run++;
      if (timeout !== t_v[i]) begin
        failures++;
        $display("[TB] FAIL timeout_pulse step %0d: got timeout=%b, expected timeout=%b",
                 i, timeout, t_v[i]);
      end
    end
  endtask
`endif

  // Scenario sequence followed by the single summary line.
  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_owner_drop();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource (a datapath slot or bus) among requesters 0..3.
- Core is a rotated 4-bit priority encoder. Priority restarts one position after the last winner, so no requester starves.
- Grants are registered and held until the owner signals completion. Sits between requester agents and the shared resource's enable/select inputs.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk
- req  input  4  request vector; bit i = requester i wants the resource; level-sensitive
- done  input  1  current owner releases the resource; sampled only in BUSY
- gnt  output  4  one-hot grant vector; all zero when no owner
- gnt_id  output  2  binary index of current owner; 2'b00 when gnt is zero
- busy  output  1  high while a grant is held (gnt != 0)
- timeout  output  1  one-cycle pulse on forced release; present only with ARB_TIMEOUT_EN

Behaviour:
- Reset (rst_n low at a clock edge):
  - gnt=4'b0000, gnt_id=2'b00, busy=0, timeout=0.
  - FSM goes to IDLE; last-winner pointer last_id=2'b11, so requester 0 has top priority first.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE with all outputs at reset values.
  - If req!=0, pick the winner w: the first set bit scanning from index (last_id+1) mod 4 upward, wrapping 3->0.
  - Next edge: gnt=1<<w, gnt_id=w, busy=1, last_id=w, go to BUSY.
  - Latency from req sampled high in IDLE to gnt high: 1 cycle.
- BUSY:
  - gnt, gnt_id and last_id hold constant.
  - Release condition: done==1, or req[gnt_id]==0 (owner abandons).
  - On release, next edge: gnt=0, gnt_id=0, busy=0, go to IDLE.
  - The other req bits are ignored in BUSY.
- Minimum one IDLE cycle between consecutive grants, so a new grant can start no earlier than 2 cycles after done is sampled.
- done sampled in IDLE is ignored. done and owner-drop in the same cycle count as a single release.
- Fairness: a requester held continuously high is granted within 4 grant periods. With all four requesting continuously and done pulsed each BUSY cycle, the grant order is 0,1,2,3,0,...
- A single requester with no contention is re-granted after each IDLE gap; the pointer does not block it.
- gnt is always one-hot or zero; it is never multi-hot.
- Reset asserted mid-grant: outputs return to reset values at that edge; pointer returns to 2'b11.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 with no release, the next edge forces a release exactly like done (gnt=0, go to IDLE) and pulses timeout=1 for one cycle.
  - The pointer still advances past the timed-out owner.
  - Counter and timeout reset to 0.
- Not defined:
  - No counter and no timeout port.
  - A grant is held indefinitely until done or owner drop.

Test Plan:
- Reset, then req=4'b0001: gnt=4'b0001, gnt_id=0, busy=1 one cycle later. Pulse done: gnt=0 next cycle.
- req=4'b1111 held, done pulsed once per BUSY cycle: grant sequence 0001,0010,0100,1000,0001. gnt=0 on every IDLE cycle between grants.
- last_id=2 (set by a prior grant to requester 2), then req=4'b0101: requester 0 wins by wrap-around, gnt=4'b0001.
- Owner 1 granted, then req[1] dropped with done=0: gnt=0 next cycle. With req=4'b1000 pending, gnt=4'b1000 one cycle after IDLE.
- rst_n pulled low while gnt=4'b0100: all outputs 0 at that edge. With req=4'b1111 after reset, the first grant is 4'b0001.
- With ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0010 held, done=0: gnt high for exactly 4 cycles, then gnt=0 and a single-cycle timeout=1 on the same edge.
